// File: rtl/bsg_credit_return_coalescer.sv
// bsg_credit_return_coalescer
//
// Gathers credit-return pulses from the consumer side into a pending
// accumulator and releases them to an up/down credit counter in bursts of at
// most max_step_p credits per cycle. A burst starts when the pending level
// reaches threshold_p, when the accumulator has been waiting for timeout_p
// cycles, or when a flush is requested. The aim is fewer counter updates with
// a bounded return latency.
//
// Ports:
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   ret_i        credits returned this cycle (0..in_step_p)
//   ret_ready_o  accumulator can absorb in_step_p more credits this cycle
//   flush_i      drain everything pending
//   up_o         credits released this cycle (drives the counter's up_i)
//   pending_o    current accumulator value
//   busy_o       not idle
//   overflow_o   sticky: a returned credit was dropped
module bsg_credit_return_coalescer #(
  parameter int max_step_p      = 2,
  parameter int in_step_p       = 2,
  parameter int threshold_p     = 4,
  parameter int timeout_p       = 8,
  parameter int pending_width_p = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [$clog2(in_step_p+1)-1:0]     ret_i,
  output logic                               ret_ready_o,
  input  logic                               flush_i,
  output logic [$clog2(max_step_p+1)-1:0]    up_o,
  output logic [pending_width_p-1:0]         pending_o,
  output logic                               busy_o,
  output logic                               overflow_o
);

  localparam int ret_w   = $clog2(in_step_p+1);
  localparam int up_w    = $clog2(max_step_p+1);
  localparam int timer_w = $clog2(timeout_p+1);
  localparam int pw      = pending_width_p;

  localparam logic [1:0] state_idle  = 2'd0;
  localparam logic [1:0] state_accum = 2'd1;
  localparam logic [1:0] state_drain = 2'd2;

  localparam logic [pw-1:0]    ready_limit = pw'((2 ** pw) - 1 - in_step_p);
  localparam logic [pw-1:0]    max_step_w  = pw'(max_step_p);
  localparam logic [pw:0]      threshold_w = (pw+1)'(threshold_p);
  localparam logic [timer_w-1:0] timer_last = timer_w'(timeout_p - 1);

  logic [1:0]         state_r, state_n;
  logic [pw-1:0]      pending_r;
  logic [timer_w-1:0] timer_r, timer_n;
  logic               overflow_r;

  logic [ret_w-1:0]   acc;
  logic [pw:0]        pending_next;
  logic               has_next;
  logic               hit_threshold;

  assign ret_ready_o = (pending_r <= ready_limit);
  assign acc         = ret_ready_o ? ret_i : '0;

  always_comb begin
    up_o = '0;
    if (state_r == state_drain) begin
      up_o = (pending_r < max_step_w) ? up_w'(pending_r) : up_w'(max_step_p);
    end
  end

  // One extra bit keeps the add/subtract exact; the ready rule guarantees the
  // result fits back into pending_r.
  assign pending_next  = {1'b0, pending_r} - (pw+1)'(up_o) + (pw+1)'(acc);
  assign has_next      = (pending_next != '0);
  assign hit_threshold = (pending_next >= threshold_w);

  always_comb begin
    state_n = state_r;
    timer_n = timer_r;
    case (state_r)
      state_idle: begin
        timer_n = '0;
        if (hit_threshold || (has_next && flush_i)) begin
          state_n = state_drain;
        end else if (has_next) begin
          state_n = state_accum;
        end
      end
      state_accum: begin
        if (hit_threshold || flush_i || (timer_r == timer_last)) begin
          state_n = state_drain;
        end else begin
          timer_n = timer_r + 1'b1;
        end
      end
      state_drain: begin
        if (!has_next) begin
          state_n = state_idle;
        end
      end
      default: begin
        state_n = state_idle;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= state_idle;
      pending_r  <= '0;
      timer_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      pending_r <= pending_next[pw-1:0];
      timer_r   <= timer_n;
      if ((ret_i != '0) && !ret_ready_o) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign pending_o  = pending_r;
  assign busy_o     = (state_r != state_idle);
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_credit_return_coalescer.sv
module tb_bsg_credit_return_coalescer;

  localparam int MAX_STEP  = 2;
  localparam int THRESHOLD = 4;
  localparam int TIMEOUT   = 8;
  localparam int READY_LIM = 255 - 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] ret;
  logic       flush;
  logic       ret_ready, busy, overflow;
  logic [1:0] up;
  logic [7:0] pending;

  logic [1:0] o_ret;
  logic       o_flush;
  logic       o_ret_ready, o_busy, o_overflow;
  logic [1:0] o_up;
  logic [7:0] o_pending;

  always #5 clk = ~clk;

  bsg_credit_return_coalescer dut (
    .clk_i(clk), .reset_n_i(reset_n), .ret_i(ret), .ret_ready_o(ret_ready),
    .flush_i(flush), .up_o(up), .pending_o(pending), .busy_o(busy),
    .overflow_o(overflow)
  );

  bsg_credit_return_coalescer #(
    .threshold_p(255), .timeout_p(255)
  ) dut_ovf (
    .clk_i(clk), .reset_n_i(reset_n), .ret_i(o_ret), .ret_ready_o(o_ret_ready),
    .flush_i(o_flush), .up_o(o_up), .pending_o(o_pending), .busy_o(o_busy),
    .overflow_o(o_overflow)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending is a plain credit count; the coalescer is idle
  // exactly when nothing is pending, otherwise it is either waiting (with an
  // age in cycles) or draining.
  int m_pend    = 0;
  int m_age     = 0;
  int m_sum_acc = 0;
  int m_sum_up  = 0;
  bit m_drain   = 1'b0;
  bit m_ovf     = 1'b0;

  function automatic int model_up(input int p, input bit d);
    if (!d) return 0;
    return (p < MAX_STEP) ? p : MAX_STEP;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend    <= 0;
      m_age     <= 0;
      m_sum_acc <= 0;
      m_sum_up  <= 0;
      m_drain   <= 1'b0;
      m_ovf     <= 1'b0;
    end else begin
      int rel, acc_m, nxt;
      bit rdy;
      rel   = model_up(m_pend, m_drain);
      rdy   = (m_pend <= READY_LIM);
      acc_m = rdy ? int'(ret) : 0;
      nxt   = m_pend - rel + acc_m;
      if (ret != 2'd0 && !rdy) m_ovf <= 1'b1;
      m_pend    <= nxt;
      m_sum_acc <= m_sum_acc + acc_m;
      m_sum_up  <= m_sum_up + int'(up);
      if (m_drain) begin
        m_drain <= (nxt > 0);
      end else if (m_pend == 0) begin
        m_drain <= (nxt >= THRESHOLD) || (nxt > 0 && flush);
        m_age   <= 0;
      end else if (nxt >= THRESHOLD || flush || m_age == TIMEOUT - 1) begin
        m_drain <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("up_o", int'(up), model_up(m_pend, m_drain));
      chk("pending_o", int'(pending), m_pend);
      chk("ret_ready_o", int'(ret_ready), int'(m_pend <= READY_LIM));
      chk("busy_o", int'(busy), int'(m_pend > 0));
      chk("overflow_o", int'(overflow), int'(m_ovf));
      chk("conservation", m_sum_up + int'(pending), m_sum_acc);
      chk("up_o_le_max", int'(int'(up) <= MAX_STEP), 1);
    end
  end

  initial begin
    int s;
    reset_n = 1'b0;
    ret     = 2'd2;
    flush   = 1'b1;
    o_ret   = 2'd2;
    o_flush = 1'b0;
    #1;
    chk("rst_up", int'(up), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_ready", int'(ret_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold_pending", int'(pending), 0);
    chk("rst_hold_busy", int'(busy), 0);
    ret   = 2'd0;
    flush = 1'b0;
    o_ret = 2'd0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_pending", int'(pending), 0);

    // Overflow on the high-threshold/long-timeout instance
    for (int i = 0; i < 127; i++) begin
      o_ret = 2'd2;
      @(negedge clk);
    end
    chk("ovf_pending_254", int'(o_pending), 254);
    chk("ovf_ready_low", int'(o_ret_ready), 0);
    chk("ovf_not_yet", int'(o_overflow), 0);
    chk("ovf_up_zero", int'(o_up), 0);
    @(negedge clk);
    chk("ovf_set", int'(o_overflow), 1);
    chk("ovf_pending_held", int'(o_pending), 254);
    o_ret = 2'd0;
    repeat (3) @(negedge clk);
    chk("ovf_sticky", int'(o_overflow), 1);

    // Threshold
    ret = 2'd2;
    @(negedge clk);
    chk("thr_c1_pending", int'(pending), 2);
    chk("thr_c1_busy", int'(busy), 1);
    chk("thr_c1_up", int'(up), 0);
    @(negedge clk);
    ret = 2'd0;
    chk("thr_c2_pending", int'(pending), 4);
    chk("thr_c2_up", int'(up), 2);
    @(negedge clk);
    chk("thr_c3_pending", int'(pending), 2);
    chk("thr_c3_up", int'(up), 2);
    @(negedge clk);
    chk("thr_c4_pending", int'(pending), 0);
    chk("thr_c4_up", int'(up), 0);
    chk("thr_c4_busy", int'(busy), 0);

    // Timeout
    ret = 2'd1;
    @(negedge clk);
    ret = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      chk("tmo_wait_busy", int'(busy), 1);
      chk("tmo_wait_up", int'(up), 0);
      @(negedge clk);
    end
    chk("tmo_c9_up", int'(up), 1);
    @(negedge clk);
    chk("tmo_c10_busy", int'(busy), 0);

    // Flush
    ret = 2'd1;
    @(negedge clk);
    ret = 2'd0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_c3_up", int'(up), 1);
    @(negedge clk);
    chk("fl_c4_busy", int'(busy), 0);
    chk("fl_c4_pending", int'(pending), 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_idle_busy", int'(busy), 0);
    chk("fl_idle_up", int'(up), 0);

    // Drain with concurrent returns
    ret = 2'd2;
    @(negedge clk);
    @(negedge clk);
    s = 0;
    for (int i = 0; i < 3; i++) begin
      chk("dc_pending4", int'(pending), 4);
      s += int'(up);
      @(negedge clk);
    end
    ret = 2'd0;
    chk("dc_pending4_last", int'(pending), 4);
    for (int k = 0; k < 10 && busy; k++) begin
      s += int'(up);
      @(negedge clk);
    end
    chk("dc_sum_up", s, 10);
    chk("dc_idle", int'(busy), 0);

    // Reset in the middle of a drain
    ret = 2'd2;
    @(negedge clk);
    @(negedge clk);
    ret = 2'd0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_up", int'(up), 0);
    chk("mid_rst_pending", int'(pending), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(ret_ready), 1);
    chk("mid_rst_ovf_clear", int'(o_overflow), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Random compliance
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ret   = 2'($urandom_range(0, 2));
      flush = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    ret   = 2'd0;
    flush = 1'b0;
    for (int k = 0; k < 40 && (busy || pending != 8'd0); k++) @(negedge clk);
    chk("final_idle", int'(busy), 0);
    chk("final_pending", int'(pending), 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_credit_return_coalescer.md
Name: bsg_credit_return_coalescer

Overview:
- Sits directly upstream of the up/down credit counter and drives that counter's up_i input.
- Collects credit-return pulses from the consumer side (0..in_step_p per cycle) into a pending accumulator.
- Releases them to the counter in bursts of at most max_step_p per cycle. A burst starts when a threshold is hit, when an idle timeout expires, or when a flush is requested.
- Purpose: fewer counter updates and bounded return latency.

Parameters:
- max_step_p, 2, max credits released on up_o per cycle (must equal the downstream counter's max_step_p); >=1
- in_step_p, 2, max credits returned on ret_i per cycle; >=1
- threshold_p, 4, pending level that triggers an immediate drain; >=1
- timeout_p, 8, ACCUM cycles before a forced drain; >=1
- pending_width_p, 8, accumulator width; max pending = 2^pending_width_p-1 (255)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous assert, active-low
- ret_i  in  $clog2(in_step_p+1)  credits returned this cycle; values > in_step_p are illegal
- ret_ready_o  out  1  accumulator can absorb in_step_p more credits this cycle
- flush_i  in  1  force a drain of everything pending
- up_o  out  $clog2(max_step_p+1)  credits released this cycle; connects to the counter's up_i
- pending_o  out  pending_width_p  current accumulator value (pending_r)
- busy_o  out  1  state != IDLE
- overflow_o  out  1  sticky error flag: a credit was dropped

Behaviour:
- Reset:
  - Async on reset_n_i=0: state=IDLE, pending_r=0, timer_r=0, overflow_r=0.
  - Hence up_o=0, busy_o=0, pending_o=0, overflow_o=0, ret_ready_o=1 immediately, with no clock needed.
  - Reset mid-drain discards pending credits. The system resets the downstream counter from the same reset.
- Acceptance:
  - ret_ready_o = (pending_r <= 2^pending_width_p-1-in_step_p).
  - acc = ret_ready_o ? ret_i : 0.
  - ret_i != 0 while ret_ready_o=0: credits dropped, overflow_r<=1. It clears only on reset.
- Release:
  - up_o = (state==DRAIN) ? min(pending_r, max_step_p) : 0. This is combinational from registered state; there is no extra latency.
- Accumulator:
  - pending_next = pending_r - up_o + acc, computed at full width.
  - It never underflows, because up_o <= pending_r.
  - It never wraps, because of the ready rule.
- FSM, evaluated on pending_next:
  - IDLE:
    - pending_next >= threshold_p -> DRAIN
    - else if pending_next > 0 and flush_i -> DRAIN
    - else if pending_next > 0 -> ACCUM with timer_r <= 0
    - else stay IDLE. flush_i with nothing pending has no effect.
  - ACCUM:
    - pending_next >= threshold_p, or flush_i, or timer_r == timeout_p-1 -> DRAIN
    - else timer_r <= timer_r+1
  - DRAIN:
    - pending_next == 0 -> IDLE
    - else stay in DRAIN. Returns arriving during a drain join the same burst.
- Simultaneous events:
  - A return in the same cycle as a release is both subtracted and added.
  - flush_i in DRAIN is ignored.
  - Threshold and timeout hit in the same cycle: DRAIN (same result).
- Timing:
  - With timeout_p=8, the first up_o pulse appears at most timeout_p+1 cycles after the first credit of an idle period.
  - Throughput: max_step_p credits per cycle while in DRAIN.
- Timer width: $clog2(timeout_p+1). timer_r is unused outside ACCUM.

Test Plan (all defaults):
- Reset: hold reset_n_i=0 with ret_i=2 and flush_i=1 -> up_o=0, pending_o=0, ret_ready_o=1, busy_o=0, overflow_o=0. Release reset -> still IDLE.
- Threshold:
  - Stimulus: ret_i=2 at cycles 0 and 1.
  - Response: cycle1 ACCUM pending=2. Cycle2 DRAIN pending=4 up_o=2. Cycle3 pending=2 up_o=2. Cycle4 IDLE pending=0 up_o=0.
- Timeout:
  - Stimulus: a single ret_i=1 at cycle 0.
  - Response: cycles1-8 ACCUM with up_o=0. Cycle9 DRAIN up_o=1. Cycle10 IDLE.
- Flush:
  - Stimulus: ret_i=1 at cycle0, flush_i=1 at cycle2.
  - Response: cycle3 DRAIN up_o=1. Cycle4 IDLE.
  - Also: flush_i alone in IDLE -> no state change.
- Drain with concurrent returns:
  - Stimulus: pending=4 in DRAIN, ret_i=2 every cycle for 3 cycles.
  - Response: up_o=2 each cycle, pending stays 4 for 3 cycles, then falls 2 -> 0. Total up_o sum = 10.
- Overflow:
  - Stimulus: flush_i=0 and ret_i=2 for 128 cycles.
  - Response: pending reaches 254 by cycle 127 via DRAIN drains offsetting returns? No drain is precluded, so instead force state via a bench with threshold_p=255, timeout_p=255: pending rises to 254 and ret_ready_o=0 at pending 254. A further ret_i=2 sets overflow_o=1, pending stays 254, and overflow_o stays 1 until reset.
- Random compliance: random ret_i/flush_i against a scoreboard -> sum(up_o) + pending_o == sum(accepted ret_i) every cycle, and up_o <= max_step_p.
